// File: rtl/mips_defs.sv
// Shared definitions for the iterative divider: FSM encoding and cycle count.
package mips_defs;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/div_unit_if.sv
// Issue/result bundle between the E stage and the divider.
interface div_unit_if
  import mips_defs::*;
#(
  parameter int WIDTH = DIV_CYCLES
);

  logic             startE;
  logic             signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             flushE;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output startE, signedE, srcaE, srcbE, flushE,
    input  stall_req, done, quotient, remainder
  );

  modport slave (
    input  startE, signedE, srcaE, srcbE, flushE,
    output stall_req, done, quotient, remainder
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the shifted remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partRem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nextRem,
  output logic             qBit
);

  logic [WIDTH-1:0] diff;

  // After a successful subtract the result is below the divisor, so the low WIDTH bits suffice.
  assign qBit    = (partRem >= {1'b0, divisor});
  assign diff    = partRem[WIDTH-1:0] - divisor;
  assign nextRem = qBit ? diff : partRem[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitude restoring division, sign fix-up on completion.
module div_unit
  import mips_defs::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic     clk,
  input  logic     reset,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  divState_t        state, nextState;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] partRem, quoShift, divisorMag;
  logic [WIDTH-1:0] quotReg, remReg;
  logic             signA, signB, isSigned;

  logic             accept, lastStep, qBit, divZero, negQ, negR;
  logic [WIDTH-1:0] magA, magB, stepRem, quoMag;
  logic [WIDTH:0]   shiftedRem;

  assign accept   = (state == IDLE) && bus.startE && !bus.flushE;
  assign lastStep = (state == CALC) && (count == LAST_STEP);

  assign magA = (bus.signedE && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
  assign magB = (bus.signedE && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

  // Dividend bits are shifted out of quoShift while quotient bits shift in behind them.
  assign shiftedRem = {partRem, quoShift[WIDTH-1]};
  assign quoMag     = {quoShift[WIDTH-2:0], qBit};

  div_step #(.WIDTH(WIDTH)) u_step (
    .partRem (shiftedRem),
    .divisor (divisorMag),
    .nextRem (stepRem),
    .qBit    (qBit)
  );

  // Divide-by-zero keeps the all-ones quotient; negating the remainder magnitude restores the dividend.
  assign divZero = (divisorMag == '0);
  assign negQ    = isSigned && (signA ^ signB) && !divZero;
  assign negR    = isSigned && signA;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = CALC;
      CALC:    if (count == LAST_STEP) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (bus.flushE) nextState = IDLE;
  end

  always_comb begin
    bus.stall_req = 1'b0;
    bus.done      = 1'b0;
    if (!reset) begin
      bus.stall_req = accept || (state == CALC);
      bus.done      = (state == DONE) && !bus.flushE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      partRem    <= '0;
      quoShift   <= '0;
      divisorMag <= '0;
      signA      <= 1'b0;
      signB      <= 1'b0;
      isSigned   <= 1'b0;
      quotReg    <= '0;
      remReg     <= '0;
    end else if (accept) begin
      count      <= '0;
      partRem    <= '0;
      quoShift   <= magA;
      divisorMag <= magB;
      signA      <= bus.srcaE[WIDTH-1];
      signB      <= bus.srcbE[WIDTH-1];
      isSigned   <= bus.signedE;
    end else if ((state == CALC) && !bus.flushE) begin
      count    <= count + CNT_W'(1);
      partRem  <= stepRem;
      quoShift <= quoMag;
      if (lastStep) begin
        quotReg <= negQ ? -quoMag : quoMag;
        remReg  <= negR ? -stepRem : stepRem;
      end
    end
  end

  assign bus.quotient  = quotReg;
  assign bus.remainder = remReg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized DIV/DIVU traffic.
module tb_div_unit;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] lastQ = '0;
  logic [W-1:0] lastR = '0;

  task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: architectural DIV/DIVU results straight from integer arithmetic.
  task automatic model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    int sa, sb;
    int unsigned ua, ub;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else begin
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
      end
    end else begin
      ua = a;
      ub = b;
      q  = ua / ub;
      r  = ua % ub;
    end
  endtask

  // Issues one divide at the next edge (cycle 0) and watches cycles 0..33.
  task automatic doDiv(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit holdStart, input string tag);
    logic [W-1:0] eq, er;
    int doneCycle, donePulses, stallCycles;
    logic stallAt33;
    model(sgn, a, b, eq, er);
    doneCycle   = -1;
    donePulses  = 0;
    stallCycles = 0;
    stallAt33   = 1'bx;
    @(posedge clk); #1;
    bus.startE  = 1'b1;
    bus.signedE = sgn;
    bus.srcaE   = a;
    bus.srcbE   = b;
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        donePulses++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (c <= 32 && bus.stall_req === 1'b1) stallCycles++;
      if (c == 33) stallAt33 = bus.stall_req;
      if (c < 33) begin
        @(posedge clk); #1;
        if (!holdStart) bus.startE = 1'b0;
      end
    end
    check({tag, " done_cycle"}, W'(doneCycle), 32'd33);
    check({tag, " done_pulses"}, W'(donePulses), 32'd1);
    check({tag, " stall_cycles"}, W'(stallCycles), 32'd33);
    check({tag, " stall_at_done"}, {31'd0, stallAt33}, 32'd0);
    check({tag, " quotient"}, bus.quotient, eq);
    check({tag, " remainder"}, bus.remainder, er);
    lastQ = eq;
    lastR = er;
  endtask

  task automatic countDone(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bit sgn;
    logic [W-1:0] a, b;
    bus.startE  = 1'b0;
    bus.signedE = 1'b0;
    bus.srcaE   = '0;
    bus.srcbE   = '0;
    bus.flushE  = 1'b0;

    // Power-on reset
    #1 reset = 1'b1;
    #1;
    check("reset quotient", bus.quotient, '0);
    check("reset remainder", bus.remainder, '0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset stall", {31'd0, bus.stall_req}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Directed arithmetic cases
    doDiv(1'b0, 32'd100, 32'd7, 1'b0, "divu_100_7");
    doDiv(1'b1, -32'sd7, 32'd2, 1'b0, "div_m7_2");
    doDiv(1'b1, 32'd7, -32'sd2, 1'b0, "div_7_m2");
    doDiv(1'b0, 32'h1234, 32'd0, 1'b0, "divu_by_zero");
    doDiv(1'b1, -32'sd5, 32'd0, 1'b0, "div_neg_by_zero");
    doDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    doDiv(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");

    // startE held through DONE, then a new divide accepted in cycle 34
    doDiv(1'b0, 32'd1000, 32'd33, 1'b1, "hold_first");
    doDiv(1'b0, 32'd81, 32'd9, 1'b0, "hold_second");

    // Flush in cycle 10 of an operation
    @(posedge clk); #1;
    bus.startE = 1'b1; bus.signedE = 1'b0; bus.srcaE = 32'd5000; bus.srcbE = 32'd7;
    @(posedge clk); #1;
    bus.startE = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flushE = 1'b1;
    @(negedge clk);
    check("flush cycle10 stall", {31'd0, bus.stall_req}, 32'd1);
    @(posedge clk); #1 bus.flushE = 1'b0;
    @(negedge clk);
    check("flush cycle11 stall", {31'd0, bus.stall_req}, 32'd0);
    countDone(40, pulses);
    check("flush done_pulses", W'(pulses), 32'd0);
    check("flush quotient held", bus.quotient, lastQ);
    check("flush remainder held", bus.remainder, lastR);

    // Flush wins over a simultaneous start
    @(posedge clk); #1;
    bus.startE = 1'b1; bus.flushE = 1'b1; bus.srcaE = 32'd50; bus.srcbE = 32'd5;
    @(negedge clk);
    check("flush_vs_start stall", {31'd0, bus.stall_req}, 32'd0);
    @(posedge clk); #1;
    bus.startE = 1'b0; bus.flushE = 1'b0;
    @(negedge clk);
    check("flush_vs_start idle stall", {31'd0, bus.stall_req}, 32'd0);
    countDone(40, pulses);
    check("flush_vs_start done_pulses", W'(pulses), 32'd0);
    check("flush_vs_start quotient held", bus.quotient, lastQ);

    // Reset mid-operation
    @(posedge clk); #1;
    bus.startE = 1'b1; bus.signedE = 1'b0; bus.srcaE = 32'hFFFF; bus.srcbE = 32'd3;
    @(posedge clk); #1;
    bus.startE = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    bus.startE = 1'b1;
    #1;
    check("midcalc reset quotient", bus.quotient, '0);
    check("midcalc reset remainder", bus.remainder, '0);
    check("midcalc reset done", {31'd0, bus.done}, 32'd0);
    check("midcalc reset stall", {31'd0, bus.stall_req}, 32'd0);
    @(negedge clk);
    bus.startE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    doDiv(1'b0, 32'd9, 32'd3, 1'b0, "after_reset_9_3");

    // Randomized traffic
    for (int i = 0; i < 20; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = -W'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      doDiv(sgn, a, b, 1'b0, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port startE, input, 1, high while a divide instruction occupies the E stage.
REQ-005 SHALL have port signedE, input, 1, selecting DIV (1) or DIVU (0); sampled with startE.
REQ-006 SHALL have ports srcaE and srcbE, input, WIDTH each, the dividend and divisor; sampled with startE.
REQ-007 SHALL have port flushE, input, 1, which cancels any operation in progress.
REQ-008 SHALL have port stall_req, output, 1, driving the stallE input of the D/E pipeline register.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking valid results for the hilo write.
REQ-010 SHALL have ports quotient and remainder, output, WIDTH each, carrying the registered results.

Function
REQ-011 SHALL implement the states IDLE, CALC and DONE.
REQ-012 IDLE: SHALL accept startE=1 with flushE=0 by latching |srcaE|, |srcbE| (magnitudes only when signedE=1), the two operand signs and signedE, clearing the iteration counter, and moving to CALC.
REQ-013 CALC: SHALL perform one radix-2 restoring step per cycle on a WIDTH+1-bit partial remainder, for exactly WIDTH cycles, then move to DONE.
REQ-014 Entering DONE: SHALL register the results with sign fix-up: quotient negated if the operand signs differ (signed mode only); remainder takes the dividend's sign.
REQ-015 DONE: SHALL assert done for exactly one cycle, then return unconditionally to IDLE; startE SHALL be ignored in DONE because it is the same instruction leaving E.
REQ-016 stall_req SHALL equal (state==IDLE & startE & ~flushE) | (state==CALC); it is combinational so the accepting cycle already stalls.
REQ-017 Latency: startE accepted in cycle 0 SHALL give done=1 and stall_req=0 in cycle WIDTH+1 (cycle 33 for WIDTH=32).
REQ-018 quotient and remainder SHALL hold their values until the next DONE entry.
REQ-019 Divisor zero: the unit SHALL still run WIDTH cycles and produce quotient = all ones and remainder = the original dividend, with no sign fix-up.
REQ-020 Signed overflow (-2^(WIDTH-1) / -1): SHALL produce quotient 0x80000000 and remainder 0.
REQ-021 flushE=1 in any state SHALL force IDLE on the next edge, suppress done, and leave quotient/remainder unchanged; flushE SHALL take priority over a simultaneous startE.

Reset
REQ-022 While reset=1, the unit SHALL immediately force state to IDLE, the counter to 0, done to 0, quotient and remainder to 0, and all operand registers to 0.
REQ-023 Reset asserted mid-CALC SHALL abandon the operation with no done pulse; stall_req SHALL read 0 while reset=1.

Structure
REQ-024 The state encoding and the DIV_CYCLES constant (= WIDTH) SHALL live in the shared package mips_defs.
REQ-025 The combinational subtract/shift step SHALL be one sub-module, div_step (inputs: partial remainder, divisor; outputs: next remainder, quotient bit).
REQ-026 The RTL SHALL stay within 120-400 lines, with no multiplier or divide operators.

Verification
REQ-027 DIVU 100/7, start at cycle 0 -> stall_req=1 in cycles 0-32, done=1 in cycle 33, quotient=14, remainder=2.
REQ-028 DIV -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; DIV 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-029 DIVU 0x1234/0 -> done in cycle 33, quotient=0xFFFFFFFF, remainder=0x00001234; DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-030 flushE=1 in cycle 10 of CALC -> IDLE in cycle 11, stall_req=0, no done pulse, prior results unchanged.
REQ-031 reset pulsed mid-CALC -> all outputs 0 immediately; a new DIVU 9/3 afterwards -> quotient=3, remainder=0 with standard latency.
REQ-032 startE held high through DONE -> exactly one done pulse; a new startE in cycle 34 is accepted.
